// File: rtl/ks_pkg.sv
// ---------------------------------------------------------------------------
// ks_pkg
// Shared constants and helpers for the ks_* family of Kogge-Stone adders.
//   clog2          : ceiling log2, used to size the prefix tree
//   ks_width_legal : legal operand widths for the ks_* adders (8/16/32/64)
//   lat_cycles     : end-to-end latency for a given number of prefix levels
// No ports (package).
// ---------------------------------------------------------------------------
package ks_pkg;

   localparam int KS_MIN_WIDTH = 8;
   localparam int KS_MAX_WIDTH = 64;

   // Ceiling log2; gives the number of prefix levels for a power-of-two width.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         result = result + 1;
      end
      return result;
   endfunction

   // Operand widths the ks_* adders are built and verified for.
   function automatic bit ks_width_legal(input int width);
      return (width == 8) || (width == 16) || (width == 32) || (width == 64);
   endfunction

   // One stage for operand preprocessing, one per prefix level, one for the
   // final sum/carry-out register.
   function automatic int lat_cycles(input int levels);
      return levels + 2;
   endfunction

endpackage

// File: rtl/black_cell.sv
// ---------------------------------------------------------------------------
// black_cell
// Kogge-Stone black cell: merges two (generate, propagate) groups where the
// lower group has not yet been resolved against the carry-in.
//   g_hi, p_hi : upper group generate/propagate
//   g_lo, p_lo : lower group generate/propagate
//   g_out      : merged group generate
//   p_out      : merged group propagate
// ---------------------------------------------------------------------------
module black_cell (
   input  logic g_hi,
   input  logic p_hi,
   input  logic g_lo,
   input  logic p_lo,
   output logic g_out,
   output logic p_out
);

   assign g_out = g_hi | (p_hi & g_lo);
   assign p_out = p_hi & p_lo;

endmodule

// File: rtl/grey_cell.sv
// ---------------------------------------------------------------------------
// grey_cell
// Kogge-Stone grey cell: the lower group already spans the carry-in, so only
// the group generate (which is then the true carry) is needed.
//   g_hi, p_hi : upper group generate/propagate
//   g_lo       : lower (resolved) group generate
//   g_out      : resolved carry out of the merged group
// ---------------------------------------------------------------------------
module grey_cell (
   input  logic g_hi,
   input  logic p_hi,
   input  logic g_lo,
   output logic g_out
);

   assign g_out = g_hi | (p_hi & g_lo);

endmodule

// File: rtl/ks_prefix_level.sv
// ---------------------------------------------------------------------------
// ks_prefix_level
// One combinational row of the Kogge-Stone prefix tree over WIDTH+1 positions.
// Position 0 holds the carry-in as a generate (position -1 of the operand);
// position j+1 holds operand bit j.
//   g_in,  p_in  : group generate/propagate from the previous level
//   g_out, p_out : group generate/propagate after combining over DIST
// Parameters: WIDTH (operand width), DIST (combining distance).
// ---------------------------------------------------------------------------
module ks_prefix_level #(
   parameter int WIDTH = 16,
   parameter int DIST  = 1
) (
   input  logic [WIDTH:0] g_in,
   input  logic [WIDTH:0] p_in,
   output logic [WIDTH:0] g_out,
   output logic [WIDTH:0] p_out
);

   // Entering this row, position m spans the DIST positions ending at m, so a
   // lower input j-DIST already reaches the carry-in exactly when j < 2*DIST:
   // those positions get a grey cell, everything further up a black cell, and
   // positions below DIST have no partner and pass straight through.
   for (genvar j = 0; j <= WIDTH; j++) begin : g_bit
      if (j < DIST) begin : g_pass
         assign g_out[j] = g_in[j];
         assign p_out[j] = p_in[j];
      end else if (j < 2 * DIST) begin : g_grey
         grey_cell u_grey (
            .g_hi  (g_in[j]),
            .p_hi  (p_in[j]),
            .g_lo  (g_in[j-DIST]),
            .g_out (g_out[j])
         );
         assign p_out[j] = p_in[j];
      end else begin : g_black
         black_cell u_black (
            .g_hi  (g_in[j]),
            .p_hi  (p_in[j]),
            .g_lo  (g_in[j-DIST]),
            .p_lo  (p_in[j-DIST]),
            .g_out (g_out[j]),
            .p_out (p_out[j])
         );
      end
   end

endmodule

// File: rtl/ks_adder_pipe.sv
// ---------------------------------------------------------------------------
// ks_adder_pipe
// Fully pipelined Kogge-Stone adder/subtractor with valid/ready handshake and
// a single global stall. Latency LAT = log2(WIDTH)+2 cycles, one result/cycle.
//   i_clk, i_rst     : clock (rising edge), synchronous active-high reset
//   i_valid, o_ready : input handshake (o_ready = i_ready | ~o_valid)
//   i_a, i_b         : operands
//   i_c0             : carry-in (borrow-in when subtracting)
//   i_sub            : 1 = compute i_a - i_b - i_c0
//   o_valid, i_ready : output handshake
//   o_sum            : result
//   o_cout           : carry-out of the MSB (1 = no borrow when subtracting)
//   o_ovf            : signed overflow
// Build option: define KS_ADDER_PIPE_OVF_EN to register the signed-overflow
// flag; otherwise o_ovf is tied to 0 with no logic behind it.
// ---------------------------------------------------------------------------
module ks_adder_pipe
   import ks_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_c0,
   input  logic             i_sub,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_cout,
   output logic             o_ovf
);

   localparam int LEVELS = clog2(WIDTH);
   localparam int LAT    = lat_cycles(LEVELS);
   localparam int NSTG   = LAT - 1;

   logic                        en;
   logic [NSTG-1:0][WIDTH:0]    g_d, g_q, p_d, p_q;
   logic [NSTG-1:0][WIDTH-1:0]  psave_d, psave_q;
   logic [NSTG-1:0]             valid_d, valid_q;
   logic [LEVELS:1][WIDTH:0]    lvl_g, lvl_p;
   logic [WIDTH-1:0]            b_eff;
   logic                        cout_w;
   logic [WIDTH-1:0]            sum_d, sum_q;
   logic                        cout_d, cout_q;
   logic                        out_valid_d, out_valid_q;
   logic                        unused_p;

   // A single stall signal: the whole pipe advances only when the output
   // register is empty or being drained this cycle.
   assign o_ready = i_ready | ~out_valid_q;
   assign en      = o_ready;

   // Prefix tree: level k reads the registers of stage k-1 and combines over
   // distance 2^(k-1).
   for (genvar gk = 1; gk <= LEVELS; gk++) begin : g_level
      ks_prefix_level #(
         .WIDTH (WIDTH),
         .DIST  (1 << (gk - 1))
      ) u_level (
         .g_in  (g_q[gk-1]),
         .p_in  (p_q[gk-1]),
         .g_out (lvl_g[gk]),
         .p_out (lvl_p[gk])
      );
   end

   // After LEVELS levels every carry up to c[WIDTH-1] is resolved, but the top
   // position only spans WIDTH operand bits; one more grey cell folds in the
   // carry-in to produce the carry-out.
   grey_cell u_cout (
      .g_hi  (g_q[NSTG-1][WIDTH]),
      .p_hi  (p_q[NSTG-1][WIDTH]),
      .g_lo  (g_q[NSTG-1][0]),
      .g_out (cout_w)
   );

   // Only the top propagate bit of the last level matters; the rest are
   // collected here so the intent is explicit.
   assign unused_p = ^p_q[NSTG-1][WIDTH-1:0];

   // Next-state of every pipeline stage. Stage 0 inverts B and the carry-in
   // for subtraction (a - b - c0 = a + ~b + ~c0) and places the effective
   // carry-in at position 0 as a pure generate. Later stages take the prefix
   // level outputs and carry the raw propagate along for the final XOR.
   always_comb begin
      g_d         = '0;
      p_d         = '0;
      psave_d     = '0;
      valid_d     = '0;
      b_eff       = i_sub ? ~i_b : i_b;
      g_d[0]      = {i_a & b_eff, i_sub ^ i_c0};
      p_d[0]      = {i_a ^ b_eff, 1'b0};
      psave_d[0]  = i_a ^ b_eff;
      valid_d[0]  = i_valid;
      for (int lvl = 1; lvl < NSTG; lvl++) begin
         g_d[lvl]     = lvl_g[lvl];
         p_d[lvl]     = lvl_p[lvl];
         psave_d[lvl] = psave_q[lvl-1];
         valid_d[lvl] = valid_q[lvl-1];
      end
      out_valid_d = valid_q[NSTG-1];
      sum_d       = psave_q[NSTG-1] ^ g_q[NSTG-1][WIDTH-1:0];
      cout_d      = cout_w;
   end

`ifdef KS_ADDER_PIPE_OVF_EN
   logic ovf_d, ovf_q;

   // Signed overflow: carry into the MSB differs from carry out of it.
   always_comb begin
      ovf_d = cout_w ^ g_q[NSTG-1][WIDTH-1];
   end

   // Overflow flag travels with the sum and is cleared by reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         ovf_q <= 1'b0;
      end else if (en) begin
         ovf_q <= ovf_d;
      end
   end

   assign o_ovf = ovf_q;
`else
   assign o_ovf = 1'b0;
`endif

   // Control and output registers: reset wins over the stall so that every
   // in-flight operation is discarded and the outputs read zero.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         valid_q     <= '0;
         out_valid_q <= 1'b0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
      end else if (en) begin
         valid_q     <= valid_d;
         out_valid_q <= out_valid_d;
         sum_q       <= sum_d;
         cout_q      <= cout_d;
      end
   end

   // Datapath registers need no reset: bubbles carry don't-care data, but it
   // is still clocked so the contents stay deterministic.
   always_ff @(posedge i_clk) begin
      if (en) begin
         g_q     <= g_d;
         p_q     <= p_d;
         psave_q <= psave_d;
      end
   end

   assign o_valid = out_valid_q;
   assign o_sum   = sum_q;
   assign o_cout  = cout_q;

endmodule
